// File: rtl/result_tx_sequencer_pkg.sv
// Shared state encoding and sizing helpers for the result byte sequencer.
// The CHECKSUM state only exists when TX_CHECKSUM_EN is defined.
package tx_seq_pkg;

    localparam int BYTE_W = 8;

    function automatic int num_bytes(input int width);
        return (width + BYTE_W - 1) / BYTE_W;
    endfunction

    // Width of the byte_count port: must hold 0..NUM_BYTES.
    function automatic int count_width(input int width);
        return $clog2(num_bytes(width) + 1);
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        GAP,
        DONE
`ifdef TX_CHECKSUM_EN
        , CHECKSUM
`endif
    } state_t;

endpackage

// File: rtl/result_tx_sequencer_byte_shift_reg.sv
// Holds the padded, send-ordered result word and presents it one byte at a time.
// With TX_CHECKSUM_EN it also keeps a running XOR of the bytes already sent.
module tx_byte_shift_reg
    import tx_seq_pkg::*;
#(
    parameter int  RESULT_WIDTH = 32,
    parameter bit  LSB_FIRST    = 1'b0,
    localparam int NUM_BYTES    = num_bytes(RESULT_WIDTH),
    localparam int PAD_W        = NUM_BYTES * BYTE_W,
    localparam int COUNT_W      = count_width(RESULT_WIDTH)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_load,
    input  logic [RESULT_WIDTH-1:0] i_word,
    input  logic [COUNT_W-1:0]      i_count,
    input  logic                    i_advance,
    output logic [7:0]              o_first_byte,
    output logic [7:0]              o_next_byte
`ifdef TX_CHECKSUM_EN
    ,
    output logic [7:0]              o_checksum
`endif
);

    logic [PAD_W-1:0] w_padded;
    logic [PAD_W-1:0] w_reversed;
    logic [PAD_W-1:0] w_ordered;
    logic [PAD_W-1:0] r_shift;

    assign w_padded = PAD_W'(i_word);

    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_reverse
            assign w_reversed[gi*BYTE_W +: BYTE_W] = w_padded[(NUM_BYTES-1-gi)*BYTE_W +: BYTE_W];
        end
    endgenerate

    // The byte to send next always sits in the top lane; MSB-first words are
    // left-aligned so that only the low i_count bytes are ever presented.
    always_comb begin
        w_ordered = w_reversed;
        if (!LSB_FIRST) begin
            w_ordered = w_padded << (BYTE_W * (NUM_BYTES - int'(i_count)));
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= w_ordered;
        end else if (i_advance) begin
            r_shift <= r_shift << BYTE_W;
        end
    end

    assign o_first_byte = w_ordered[PAD_W-1 -: BYTE_W];

    generate
        if (NUM_BYTES > 1) begin : g_next
            assign o_next_byte = r_shift[PAD_W-BYTE_W-1 -: BYTE_W];
        end else begin : g_no_next
            assign o_next_byte = '0;
        end
    endgenerate

`ifdef TX_CHECKSUM_EN
    logic [7:0] r_xor;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_xor <= '0;
        end else if (i_load) begin
            r_xor <= '0;
        end else if (i_advance) begin
            r_xor <= r_xor ^ r_shift[PAD_W-1 -: BYTE_W];
        end
    end

    // Includes the byte currently on the line, so it is final at the last advance.
    assign o_checksum = r_xor ^ r_shift[PAD_W-1 -: BYTE_W];
`endif

endmodule

// File: rtl/result_tx_sequencer.sv
// Serialises one result word into UART bytes and reports completion with tx_sent.
// Defining TX_CHECKSUM_EN appends an XOR checksum byte after the data bytes.
module result_tx_sequencer
    import tx_seq_pkg::*;
#(
    parameter int  RESULT_WIDTH   = 32,
    parameter bit  LSB_FIRST      = 1'b0,
    parameter int  INTER_BYTE_GAP = 0,
    localparam int NUM_BYTES      = num_bytes(RESULT_WIDTH),
    localparam int COUNT_W        = count_width(RESULT_WIDTH)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [RESULT_WIDTH-1:0] i_result,
    input  logic [COUNT_W-1:0]      i_byte_count,
    input  logic                    i_tx_busy,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_start_byte,
    output logic                    o_tx_sent,
    output logic                    o_busy,
    output logic                    o_overrun
);

    localparam logic [COUNT_W-1:0] NUM_BYTES_C = COUNT_W'(NUM_BYTES);
    localparam logic [7:0] GAP_LOAD = (INTER_BYTE_GAP > 0) ? 8'(INTER_BYTE_GAP - 1) : 8'd0;
    localparam state_t AFTER_BYTE = (INTER_BYTE_GAP > 0) ? GAP : ISSUE;

    state_t             r_state;
    logic [COUNT_W-1:0] r_remaining;
    logic [7:0]         r_gap_cnt;
    logic [7:0]         r_tx_data;
    logic               r_tx_start_byte;
    logic               r_tx_sent;
    logic               r_busy;
    logic               r_overrun;

    logic [COUNT_W-1:0] w_eff_count;
    logic               w_accept;
    logic               w_advance;
    logic [7:0]         w_first_byte;
    logic [7:0]         w_next_byte;

    always_comb begin
        w_eff_count = i_byte_count;
        if (i_byte_count == '0 || i_byte_count > NUM_BYTES_C) begin
            w_eff_count = NUM_BYTES_C;
        end
    end

    // busy stays high through the tx_sent cycle, so a start there is refused.
    assign w_accept  = i_start && (r_state == IDLE) && !r_busy;
    assign w_advance = (r_state == WAIT_DONE) && !i_tx_busy;

`ifdef TX_CHECKSUM_EN
    logic       r_csum_phase;
    logic [7:0] w_checksum;
`endif

    tx_byte_shift_reg #(
        .RESULT_WIDTH (RESULT_WIDTH),
        .LSB_FIRST    (LSB_FIRST)
    ) u_shift (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load       (w_accept),
        .i_word       (i_result),
        .i_count      (w_eff_count),
        .i_advance    (w_advance),
        .o_first_byte (w_first_byte),
        .o_next_byte  (w_next_byte)
`ifdef TX_CHECKSUM_EN
        ,
        .o_checksum   (w_checksum)
`endif
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_remaining     <= '0;
            r_gap_cnt       <= '0;
            r_tx_data       <= '0;
            r_tx_start_byte <= 1'b0;
            r_tx_sent       <= 1'b0;
            r_busy          <= 1'b0;
            r_overrun       <= 1'b0;
`ifdef TX_CHECKSUM_EN
            r_csum_phase    <= 1'b0;
`endif
        end else begin
            r_tx_start_byte <= 1'b0;
            r_tx_sent       <= 1'b0;
            if (i_start && !w_accept) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (w_accept) begin
                        r_busy      <= 1'b1;
                        r_overrun   <= 1'b0;
                        r_tx_data   <= w_first_byte;
                        r_remaining <= w_eff_count;
`ifdef TX_CHECKSUM_EN
                        r_csum_phase <= 1'b0;
`endif
                        // Idle UART: strobe straight away so the first byte leaves one cycle after start.
                        if (!i_tx_busy) begin
                            r_tx_start_byte <= 1'b1;
                            r_state         <= WAIT_ACK;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (!i_tx_busy) begin
                        r_tx_start_byte <= 1'b1;
                        r_state         <= WAIT_ACK;
                    end
                end

                WAIT_ACK: begin
                    if (i_tx_busy) begin
                        r_state <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if (r_remaining > COUNT_W'(1)) begin
                            r_remaining <= r_remaining - COUNT_W'(1);
                            r_tx_data   <= w_next_byte;
                            r_gap_cnt   <= GAP_LOAD;
                            r_state     <= AFTER_BYTE;
                        end else begin
                            r_remaining <= '0;
`ifdef TX_CHECKSUM_EN
                            if (!r_csum_phase) begin
                                r_csum_phase <= 1'b1;
                                r_tx_data    <= w_checksum;
                                r_state      <= CHECKSUM;
                            end else begin
                                r_state <= DONE;
                            end
`else
                            r_state <= DONE;
`endif
                        end
                    end
                end

`ifdef TX_CHECKSUM_EN
                CHECKSUM: begin
                    r_gap_cnt <= GAP_LOAD;
                    r_state   <= AFTER_BYTE;
                end
`endif

                GAP: begin
                    if (r_gap_cnt == 8'd0) begin
                        r_state <= ISSUE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end

                DONE: begin
                    r_tx_sent <= 1'b1;
                    r_state   <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_tx_data       = r_tx_data;
    assign o_tx_start_byte = r_tx_start_byte;
    assign o_tx_sent       = r_tx_sent;
    assign o_busy          = r_busy;
    assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_result_tx_sequencer.sv
// Directed bench for result_tx_sequencer: an MSB-first and an LSB-first instance,
// each driving a simple UART model that stays busy 10 cycles per byte.
module tb_result_tx_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start [2];
    logic [31:0] result [2];
    logic [2:0] bcnt [2];
    logic       force_busy [2];
    logic       tx_busy [2];
    logic [7:0] tx_data [2];
    logic       tx_start_byte [2];
    logic       tx_sent [2];
    logic       busy [2];
    logic       overrun [2];

    int         uart_cnt [2] = '{0, 0};
    int         strobes [2] = '{0, 0};
    int         sents [2] = '{0, 0};
    int         doubles [2] = '{0, 0};
    int         ncap [2] = '{0, 0};
    logic       prev_strobe [2] = '{1'b0, 1'b0};
    logic [7:0] cap [2][128];

    logic [7:0] exp_b [8];
    int         nexp;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    result_tx_sequencer #(.RESULT_WIDTH(32), .LSB_FIRST(1'b0), .INTER_BYTE_GAP(0)) dut_msb (
        .i_clk(clk), .i_reset(rst), .i_start(start[0]), .i_result(result[0]),
        .i_byte_count(bcnt[0]), .i_tx_busy(tx_busy[0]), .o_tx_data(tx_data[0]),
        .o_tx_start_byte(tx_start_byte[0]), .o_tx_sent(tx_sent[0]), .o_busy(busy[0]),
        .o_overrun(overrun[0])
    );

    result_tx_sequencer #(.RESULT_WIDTH(32), .LSB_FIRST(1'b1), .INTER_BYTE_GAP(0)) dut_lsb (
        .i_clk(clk), .i_reset(rst), .i_start(start[1]), .i_result(result[1]),
        .i_byte_count(bcnt[1]), .i_tx_busy(tx_busy[1]), .o_tx_data(tx_data[1]),
        .o_tx_start_byte(tx_start_byte[1]), .o_tx_sent(tx_sent[1]), .o_busy(busy[1]),
        .o_overrun(overrun[1])
    );

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            tx_busy[k] = force_busy[k] || (uart_cnt[k] != 0);
        end
    end

    // UART model and event recorder; not reset, so a byte in flight finishes.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (tx_start_byte[k] === 1'b1) begin
                strobes[k] <= strobes[k] + 1;
                if (ncap[k] < 128) cap[k][ncap[k]] <= tx_data[k];
                ncap[k] <= ncap[k] + 1;
                uart_cnt[k] <= 10;
            end else if (uart_cnt[k] > 0) begin
                uart_cnt[k] <= uart_cnt[k] - 1;
            end
            if (tx_start_byte[k] === 1'b1 && prev_strobe[k] === 1'b1) doubles[k] <= doubles[k] + 1;
            prev_strobe[k] <= tx_start_byte[k];
            if (tx_sent[k] === 1'b1) sents[k] <= sents[k] + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int k, input logic [31:0] res, input logic [2:0] bc);
        result[k] = res;
        bcnt[k]   = bc;
        start[k]  = 1'b1;
        @(posedge clk);
        #1;
        start[k]  = 1'b0;
    endtask

    task automatic wait_sent(input int k, output bit timed_out);
        int c;
        c = 0;
        timed_out = 1'b0;
        while (tx_sent[k] !== 1'b1) begin
            if (c >= 400) begin
                timed_out = 1'b1;
                break;
            end
            tick(1);
            c++;
        end
    endtask

    task automatic finish_expect();
`ifdef TX_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < nexp; i++) x = x ^ exp_b[i];
        exp_b[nexp] = x;
        nexp++;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({tx_data[k], tx_start_byte[k], tx_sent[k], busy[k], overrun[k]} !== 12'h000) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: data=%02h stb=%b sent=%b busy=%b ovr=%b required all 0",
                         k, tx_data[k], tx_start_byte[k], tx_sent[k], busy[k], overrun[k]);
            end
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_msb_word();
        int s0, n0, t0, d0;
        bit to;
        for (int row = 0; row < 2; row++) begin
            if (row == 0) begin
                exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4; nexp = 4;
            end else begin
                exp_b[0] = 8'hD4; nexp = 1;
            end
            finish_expect();
            s0 = strobes[0]; n0 = ncap[0]; t0 = sents[0]; d0 = doubles[0];
            pulse_start(0, 32'hA1B2C3D4, (row == 0) ? 3'd4 : 3'd1);
            checks++;
            if (tx_start_byte[0] !== 1'b1 || tx_data[0] !== exp_b[0] || busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL msb_first_strobe row%0d: stb=%b data=%02h busy=%b required 1 %02h 1",
                         row, tx_start_byte[0], tx_data[0], busy[0], exp_b[0]);
            end
            wait_sent(0, to);
            checks++;
            if (to) begin errors++; $display("FAIL msb_timeout row%0d: tx_sent never seen", row); end
            tick(1);
            checks++;
            if (busy[0] !== 1'b0 || sents[0] - t0 !== 1) begin
                errors++;
                $display("FAIL msb_done row%0d: busy=%b sent_pulses=%0d required 0 and 1", row, busy[0], sents[0] - t0);
            end
            checks++;
            if (strobes[0] - s0 !== nexp || doubles[0] - d0 !== 0) begin
                errors++;
                $display("FAIL msb_strobes row%0d: strobes=%0d long=%0d required %0d and 0",
                         row, strobes[0] - s0, doubles[0] - d0, nexp);
            end
            for (int i = 0; i < nexp; i++) begin
                checks++;
                if (cap[0][n0+i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL msb_byte row%0d[%0d]: got %02h required %02h", row, i, cap[0][n0+i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_lsb_words();
        int s0, n0, t0;
        bit to;
        logic [31:0] res;
        logic [2:0] bc;
        for (int row = 0; row < 3; row++) begin
            case (row)
                0: begin res = 32'h00001234; bc = 3'd2;
                          exp_b[0] = 8'h34; exp_b[1] = 8'h12; nexp = 2; end
                1: begin res = 32'h00001234; bc = 3'd0;
                          exp_b[0] = 8'h34; exp_b[1] = 8'h12; exp_b[2] = 8'h00; exp_b[3] = 8'h00; nexp = 4; end
                default: begin res = 32'hCAFEBABE; bc = 3'd5;
                          exp_b[0] = 8'hBE; exp_b[1] = 8'hBA; exp_b[2] = 8'hFE; exp_b[3] = 8'hCA; nexp = 4; end
            endcase
            finish_expect();
            s0 = strobes[1]; n0 = ncap[1]; t0 = sents[1];
            pulse_start(1, res, bc);
            wait_sent(1, to);
            checks++;
            if (to) begin errors++; $display("FAIL lsb_timeout row%0d: tx_sent never seen", row); end
            tick(1);
            checks++;
            if (strobes[1] - s0 !== nexp || sents[1] - t0 !== 1 || busy[1] !== 1'b0) begin
                errors++;
                $display("FAIL lsb_counts row%0d: strobes=%0d sent=%0d busy=%b required %0d 1 0",
                         row, strobes[1] - s0, sents[1] - t0, busy[1], nexp);
            end
            for (int i = 0; i < nexp; i++) begin
                checks++;
                if (cap[1][n0+i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL lsb_byte row%0d[%0d]: got %02h required %02h", row, i, cap[1][n0+i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int s0, n0, t0;
        bit to;
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44; nexp = 4;
        finish_expect();
        s0 = strobes[0]; n0 = ncap[0]; t0 = sents[0];
        pulse_start(0, 32'h11223344, 3'd4);
        tick(2);
        pulse_start(0, 32'hDEADBEEF, 3'd4);
        checks++;
        if (overrun[0] !== 1'b1 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: overrun=%b busy=%b required 1 1", overrun[0], busy[0]);
        end
        wait_sent(0, to);
        checks++;
        if (to) begin errors++; $display("FAIL overrun_timeout: tx_sent never seen"); end
        tick(1);
        checks++;
        if (sents[0] - t0 !== 1 || strobes[0] - s0 !== nexp || overrun[0] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_stream: sent=%0d strobes=%0d overrun=%b required 1 %0d 1",
                     sents[0] - t0, strobes[0] - s0, overrun[0], nexp);
        end
        for (int i = 0; i < nexp; i++) begin
            checks++;
            if (cap[0][n0+i] !== exp_b[i]) begin
                errors++;
                $display("FAIL overrun_byte[%0d]: got %02h required %02h", i, cap[0][n0+i], exp_b[i]);
            end
        end
        // A legal start clears the flag; a start in the tx_sent cycle sets it again.
        pulse_start(0, 32'h55667788, 3'd2);
        checks++;
        if (overrun[0] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: overrun=%b required 0", overrun[0]);
        end
        wait_sent(0, to);
        checks++;
        if (to) begin errors++; $display("FAIL overrun_timeout2: tx_sent never seen"); end
        s0 = strobes[0];
        pulse_start(0, 32'h99999999, 3'd4);
        checks++;
        if (overrun[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_at_sent: overrun=%b busy=%b required 1 0", overrun[0], busy[0]);
        end
        tick(5);
        checks++;
        if (strobes[0] - s0 !== 0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_ignored: strobes=%0d busy=%b required 0 0", strobes[0] - s0, busy[0]);
        end
        exp_b[0] = 8'h0A; exp_b[1] = 8'h0B; exp_b[2] = 8'h0C; exp_b[3] = 8'h0D; nexp = 4;
        finish_expect();
        n0 = ncap[0];
        pulse_start(0, 32'h0A0B0C0D, 3'd4);
        checks++;
        if (overrun[0] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear2: overrun=%b required 0", overrun[0]);
        end
        wait_sent(0, to);
        tick(1);
        for (int i = 0; i < nexp; i++) begin
            checks++;
            if (cap[0][n0+i] !== exp_b[i]) begin
                errors++;
                $display("FAIL after_overrun_byte[%0d]: got %02h required %02h", i, cap[0][n0+i], exp_b[i]);
            end
        end
    endtask

    task automatic test_busy_hold();
        int s0, n0, t0, d0;
        bit to;
        exp_b[0] = 8'hBE; exp_b[1] = 8'hBA; exp_b[2] = 8'hFE; exp_b[3] = 8'hCA; nexp = 4;
        finish_expect();
        s0 = strobes[1]; n0 = ncap[1]; t0 = sents[1]; d0 = doubles[1];
        force_busy[1] = 1'b1;
        pulse_start(1, 32'hCAFEBABE, 3'd4);
        tick(20);
        checks++;
        if (strobes[1] - s0 !== 0 || tx_start_byte[1] !== 1'b0 || busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL hold_withheld: strobes=%0d stb=%b busy=%b required 0 0 1",
                     strobes[1] - s0, tx_start_byte[1], busy[1]);
        end
        force_busy[1] = 1'b0;
        tick(1);
        checks++;
        if (tx_start_byte[1] !== 1'b1 || tx_data[1] !== 8'hBE) begin
            errors++;
            $display("FAIL hold_release: stb=%b data=%02h required 1 be", tx_start_byte[1], tx_data[1]);
        end
        tick(1);
        checks++;
        if (tx_start_byte[1] !== 1'b0) begin
            errors++;
            $display("FAIL hold_one_cycle: stb=%b required 0", tx_start_byte[1]);
        end
        wait_sent(1, to);
        checks++;
        if (to) begin errors++; $display("FAIL hold_timeout: tx_sent never seen"); end
        tick(1);
        checks++;
        if (strobes[1] - s0 !== nexp || sents[1] - t0 !== 1 || doubles[1] - d0 !== 0) begin
            errors++;
            $display("FAIL hold_counts: strobes=%0d sent=%0d long=%0d required %0d 1 0",
                     strobes[1] - s0, sents[1] - t0, doubles[1] - d0, nexp);
        end
        for (int i = 0; i < nexp; i++) begin
            checks++;
            if (cap[1][n0+i] !== exp_b[i]) begin
                errors++;
                $display("FAIL hold_byte[%0d]: got %02h required %02h", i, cap[1][n0+i], exp_b[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        int s0, n0, t0, c;
        bit to;
        s0 = strobes[0]; t0 = sents[0];
        pulse_start(0, 32'hA1B2C3D4, 3'd4);
        c = 0;
        while (strobes[0] - s0 < 2 && c < 200) begin
            tick(1);
            c++;
        end
        checks++;
        if (strobes[0] - s0 < 2) begin errors++; $display("FAIL areset_timeout: second byte never issued"); end
        tick(4);
        checks++;
        if (tx_data[0] !== 8'hB2 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: data=%02h busy=%b required b2 1", tx_data[0], busy[0]);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({tx_data[0], tx_start_byte[0], tx_sent[0], busy[0], overrun[0]} !== 12'h000) begin
            errors++;
            $display("FAIL areset_immediate: data=%02h stb=%b sent=%b busy=%b ovr=%b required all 0",
                     tx_data[0], tx_start_byte[0], tx_sent[0], busy[0], overrun[0]);
        end
        @(posedge clk);
        #1;
        tick(2);
        rst = 1'b0;
        tick(15);
        checks++;
        if (sents[0] - t0 !== 0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL areset_no_sent: sent=%0d busy=%b required 0 0", sents[0] - t0, busy[0]);
        end
        exp_b[0] = 8'h0B; exp_b[1] = 8'hAD; exp_b[2] = 8'hF0; exp_b[3] = 8'h0D; nexp = 4;
        finish_expect();
        s0 = strobes[0]; n0 = ncap[0]; t0 = sents[0];
        pulse_start(0, 32'h0BADF00D, 3'd4);
        wait_sent(0, to);
        checks++;
        if (to) begin errors++; $display("FAIL areset_resend_timeout: tx_sent never seen"); end
        tick(1);
        checks++;
        if (strobes[0] - s0 !== nexp || sents[0] - t0 !== 1) begin
            errors++;
            $display("FAIL areset_resend_counts: strobes=%0d sent=%0d required %0d 1",
                     strobes[0] - s0, sents[0] - t0, nexp);
        end
        for (int i = 0; i < nexp; i++) begin
            checks++;
            if (cap[0][n0+i] !== exp_b[i]) begin
                errors++;
                $display("FAIL areset_byte[%0d]: got %02h required %02h", i, cap[0][n0+i], exp_b[i]);
            end
        end
    endtask

`ifdef TX_CHECKSUM_EN
    task automatic test_checksum();
        int n0, t0;
        bit to;
        logic [31:0] res;
        for (int row = 0; row < 3; row++) begin
            case (row)
                0: begin res = 32'h00112233;
                          exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h00; end
                1: begin res = 32'h00010203;
                          exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03; exp_b[3] = 8'h00; end
                default: begin res = 32'h00010204;
                          exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h04; exp_b[3] = 8'h07; end
            endcase
            n0 = ncap[0]; t0 = sents[0];
            pulse_start(0, res, 3'd3);
            wait_sent(0, to);
            checks++;
            if (to) begin errors++; $display("FAIL csum_timeout row%0d: tx_sent never seen", row); end
            tick(1);
            checks++;
            if (ncap[0] - n0 !== 4 || sents[0] - t0 !== 1) begin
                errors++;
                $display("FAIL csum_counts row%0d: bytes=%0d sent=%0d required 4 1", row, ncap[0] - n0, sents[0] - t0);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cap[0][n0+i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL csum_byte row%0d[%0d]: got %02h required %02h", row, i, cap[0][n0+i], exp_b[i]);
                end
            end
        end
    endtask
`endif

    initial begin
        start      = '{1'b0, 1'b0};
        result     = '{32'h0, 32'h0};
        bcnt       = '{3'd0, 3'd0};
        force_busy = '{1'b0, 1'b0};
        rst        = 1'b1;
        test_reset();
        test_msb_word();
        test_lsb_words();
        test_overrun();
        test_busy_hold();
        test_async_reset();
`ifdef TX_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_tx_sequencer.md
Name: result_tx_sequencer

Overview:
- Serialises one multi-byte result word from the vector datapath (READ element, SUM/AVG element, EUC/MAN distance, dot product) into bytes for the single UART transmitter.
- Sits between the control unit and the UART TX.
- Accepts a `start` pulse plus result word and per-operation byte count.
- Sequences the UART byte handshake and returns a single `tx_sent` pulse to the control unit when the whole word has left.

Parameters:
- RESULT_WIDTH, 32, width of result bus; NUM_BYTES = ceil(RESULT_WIDTH/8), upper bytes zero-padded.
- LSB_FIRST, 0, 0 = most-significant byte sent first, 1 = least-significant first.
- INTER_BYTE_GAP, 0, idle cycles inserted between consecutive bytes (0..255).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request from control unit (its tx_start).
- result  input  RESULT_WIDTH  word to send; sampled only on accepted start.
- byte_count  input  $clog2(NUM_BYTES+1)  bytes to send; sampled with start; 0 or >NUM_BYTES means NUM_BYTES.
- tx_busy  input  1  UART TX busy flag.
- tx_data  output  8  byte to UART.
- tx_start_byte  output  1  one-cycle UART start strobe.
- tx_sent  output  1  one-cycle pulse: whole word transmitted.
- busy  output  1  high from accepted start until the cycle after tx_sent.
- overrun  output  1  sticky: start arrived while busy; cleared by reset or next accepted start.

Behaviour:
- Reset (async): state IDLE; tx_data=0, tx_start_byte=0, tx_sent=0, busy=0, overrun=0; shift register and counters cleared.
- Reset mid-word aborts immediately. A UART byte already in flight completes inside the UART; no tx_sent is generated.
- All outputs are registered.
- States:
  - IDLE: start=1 → latch result (padded, reordered per LSB_FIRST) and effective count; busy=1; overrun=0; go ISSUE.
  - ISSUE: wait for tx_busy=0. Then tx_start_byte=1 for exactly one cycle with tx_data=current byte; go WAIT_ACK.
  - WAIT_ACK: wait for tx_busy=1 (UART accepted); go WAIT_DONE. tx_data held stable.
  - WAIT_DONE: wait for tx_busy=0; decrement remaining count, shift next byte. If remaining>0: go GAP if INTER_BYTE_GAP>0, else ISSUE. If remaining=0: go DONE.
  - GAP: count INTER_BYTE_GAP cycles, then ISSUE.
  - DONE: tx_sent=1 for one cycle; go IDLE, busy=0 next cycle.
- Latency, idle UART, gap 0:
  - start sampled at cycle N → tx_start_byte at N+1.
  - Each subsequent byte strobe issues the cycle after tx_busy falls + 1.
  - tx_sent asserts 2 cycles after the last tx_busy fall.
- start while busy is ignored (no relatch) and sets overrun.
- start coincident with DONE cycle is also ignored and sets overrun. The controller must wait for tx_sent.
- tx_data changes only in IDLE latch or on the WAIT_DONE exit.

Optional Feature:
- Macro TX_CHECKSUM_EN.
- Defined: after the last data byte, one extra byte is sent equal to the XOR of all transmitted data bytes, through the same ISSUE/WAIT_ACK/WAIT_DONE (and GAP) sequence. tx_sent asserts only after the checksum byte.
- Undefined: no checksum logic or state exists; tx_sent follows the last data byte.

Decomposition:
- Package tx_seq_pkg: state enum (IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP, DONE, plus CHECKSUM under macro), function computing NUM_BYTES from RESULT_WIDTH, byte-count width constant.
- One sub-module, tx_byte_shift_reg: loads padded/reordered word, presents current byte, shifts by 8 on advance, accumulates XOR under TX_CHECKSUM_EN.

Test Plan:
- MSB first, RESULT_WIDTH=32, byte_count=4, result=0xA1B2C3D4, UART model busy 10 cycles/byte → bytes A1,B2,C3,D4 in order; exactly 4 tx_start_byte pulses; one tx_sent; busy low after.
- LSB_FIRST=1, byte_count=2, result=0x00001234 → bytes 34,12; byte_count=0 → 4 bytes 34,12,00,00.
- start again 3 cycles after first accept → overrun=1, stream unchanged, tx_sent once; next legal start clears overrun.
- tx_busy held high on ISSUE entry for 20 cycles → tx_start_byte withheld until tx_busy low, then one-cycle strobe.
- Async reset asserted in WAIT_DONE of byte 2 → all outputs 0 immediately, no tx_sent; new start after release sends full word correctly.
- TX_CHECKSUM_EN defined, byte_count=3, result=0x00112233 → bytes 11,22,33,00 (11^22^33=00); then result=0x00010203 → 01,02,03,00; with 0x00010204 → trailing 07.
